// File: rtl/mem_access_unit_if.sv
// Request/response bus of the memory-access unit: the core drives requests as master,
// the unit accepts them and returns one completion pulse per request as slave.
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_mode;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_misalign;

  modport master (
    output req_valid, req_write, req_mode, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign
  );

  modport slave (
    input  req_valid, req_write, req_mode, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: one request at a time, big-endian byte lanes (lane 0 is the
// MSB byte), zero/sign-extended loads, misaligned or illegal accesses flagged rather than done.
module mem_access_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RD_LATENCY = 1,
  localparam int unsigned NB = DATA_W / 8,
  localparam int unsigned BB = $clog2(NB)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_access_unit_if.slave     bus,
  output logic [ADDR_W-BB-1:0] ram_addr,
  output logic                 ram_wren,
  output logic [NB-1:0]        ram_byteen,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata
);

  localparam logic [2:0] ModeWord   = 3'd0;
  localparam logic [2:0] ModeByte   = 3'd1;
  localparam logic [2:0] ModeByteS  = 3'd2;
  localparam logic [2:0] ModeHword  = 3'd3;
  localparam logic [2:0] ModeHwordS = 3'd4;

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  state_e        state_q;
  logic          write_q;
  logic          err_q;
  logic [2:0]    mode_q;
  logic [BB-1:0] off_q;
  logic [1:0]    wait_q;

  logic          accept;
  logic          acc_err;
  logic [BB-1:0] req_off;
  int unsigned   req_lane;
  int unsigned   ld_lane;
  logic [NB-1:0]     st_byteen;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign bus.req_ready = (state_q == StIdle) || (state_q == StResp);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_off       = bus.req_addr[BB-1:0];

  // Request decode: alignment check and lane placement of store data.
  always_comb begin
    req_lane  = 32'(req_off);
    acc_err   = 1'b0;
    st_byteen = '1;
    st_wdata  = bus.req_wdata;
    case (bus.req_mode)
      ModeWord: begin
        acc_err = (req_off != '0);
      end
      ModeByte, ModeByteS: begin
        st_byteen = NB'(1) << (NB - 1 - req_lane);
        st_wdata  = DATA_W'(bus.req_wdata[7:0]) << (8 * (NB - 1 - req_lane));
      end
      ModeHword, ModeHwordS: begin
        acc_err   = req_off[0];
        st_byteen = NB'(3) << (NB - 2 - req_lane);
        st_wdata  = DATA_W'(bus.req_wdata[15:0]) << (8 * (NB - 2 - req_lane));
      end
      default: begin
        acc_err = 1'b1;
      end
    endcase
  end

  // Load extraction mirrors the store lane mapping.
  always_comb begin
    ld_lane = 32'(off_q);
    ld_byte = 8'(ram_rdata >> (8 * (NB - 1 - ld_lane)));
    ld_half = 16'(ram_rdata >> (8 * (NB - 2 - ld_lane)));
    case (mode_q)
      ModeWord:   ld_data = ram_rdata;
      ModeByte:   ld_data = DATA_W'(ld_byte);
      ModeByteS:  ld_data = {{(DATA_W - 8){ld_byte[7]}}, ld_byte};
      ModeHword:  ld_data = DATA_W'(ld_half);
      ModeHwordS: ld_data = {{(DATA_W - 16){ld_half[15]}}, ld_half};
      default:    ld_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= StIdle;
      write_q           <= 1'b0;
      err_q             <= 1'b0;
      mode_q            <= '0;
      off_q             <= '0;
      wait_q            <= '0;
      ram_addr          <= '0;
      ram_wren          <= 1'b0;
      ram_byteen        <= '0;
      ram_wdata         <= '0;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.resp_misalign <= 1'b0;
    end else begin
      // Response outputs are a single-cycle pulse; zero unless set below.
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.resp_misalign <= 1'b0;
      case (state_q)
        StIdle, StResp: begin
          if (accept) begin
            write_q    <= bus.req_write;
            err_q      <= acc_err;
            mode_q     <= bus.req_mode;
            off_q      <= req_off;
            ram_addr   <= bus.req_addr[ADDR_W-1:BB];
            ram_wren   <= bus.req_write && !acc_err;
            ram_byteen <= acc_err ? '0 : (bus.req_write ? st_byteen : '1);
            ram_wdata  <= (bus.req_write && !acc_err) ? st_wdata : '0;
            state_q    <= StAccess;
          end else begin
            state_q <= StIdle;
          end
        end
        StAccess: begin
          ram_wren   <= 1'b0;
          ram_byteen <= '0;
          ram_wdata  <= '0;
          wait_q     <= '0;
          if (write_q || err_q) begin
            bus.resp_valid    <= 1'b1;
            bus.resp_misalign <= err_q;
            state_q           <= StResp;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          // ram_addr is left untouched so the RAM sees a stable address.
          if (wait_q == 2'(RD_LATENCY - 1)) begin
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= ld_data;
            state_q        <= StResp;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
